jtag_ram_param: RTL and testbench

//  Parametrised register-file RAM with a serial word-wide scan chain for bulk load and readout.
//  The host port does single-word write and read by address.
//  The scan port shifts whole words through all entries.

---
 rtl/jtag_ram_param_if.sv | 31 +++
 rtl/jtag_ram_param.sv | 82 ++++++++
 tb/tb_jtag_ram_param.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_ram_param_if.sv
// jtag_ram_param_if
//  Bundles the host word port and the scan-chain port of jtag_ram_param.
//  master : the side that drives addresses, data and scan controls (CPU / loader / bench)
//  slave  : the RAM itself
//  Host : Addr, Din, Wen -> RAM ; Dout <- RAM
//  Scan : Jen, Jrot, Jin -> RAM ; Jout, Jcnt, Jdone <- RAM
interface jtag_ram_param_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] Addr;
  logic [WIDTH-1:0]  Din;
  logic              Wen;
  logic [WIDTH-1:0]  Dout;
  logic              Jen;
  logic              Jrot;
  logic [WIDTH-1:0]  Jin;
  logic [WIDTH-1:0]  Jout;
  logic [ADDR_W-1:0] Jcnt;
  logic              Jdone;

  modport master (
    output Addr, Din, Wen, Jen, Jrot, Jin,
    input  Dout, Jout, Jcnt, Jdone
  );

  modport slave (
    input  Addr, Din, Wen, Jen, Jrot, Jin,
    output Dout, Jout, Jcnt, Jdone
  );
endinterface

// File: rtl/jtag_ram_param.sv
// jtag_ram_param
//  Register-file RAM with a word-wide scan chain. The host side writes and reads
//  single words by address; the scan side shifts whole words through every entry,
//  optionally rotating the last entry back into entry 0 for a non-destructive dump.
//  A shift counter tracks position within one image and Jdone pulses for one cycle
//  after each complete image of DEPTH shifts.
//  Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, clears contents, count, pulse, read register
//   bus   : jtag_ram_param_if.slave carrying the host and scan signals
//  Parameters: WIDTH word width, DEPTH entries (power of two), ADDR_W = log2(DEPTH),
//  READ_REG selects combinational (0) or one-cycle registered (1) host read.
module jtag_ram_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 8,
  parameter int ADDR_W   = 3,
  parameter bit READ_REG = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  jtag_ram_param_if.slave   bus
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] jcnt;
  logic              jdone;

  // Storage: reset wins, then scan shift, then host write. During a shift every
  // entry moves up by one, so a host write in the same cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.Jen) begin
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
      mem[0] <= bus.Jrot ? mem[DEPTH-1] : bus.Jin;
    end else if (bus.Wen) begin
      mem[bus.Addr] <= bus.Din;
    end
  end

  // Shift counter wraps naturally because DEPTH == 2**ADDR_W. Jdone is set on the
  // edge where the count rolls over, so it is visible in the following cycle only.
  // A pause in Jen freezes the count, keeping a partial image pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      jcnt  <= '0;
      jdone <= 1'b0;
    end else begin
      jdone <= bus.Jen && (jcnt == ADDR_W'(DEPTH - 1));
      if (bus.Jen) begin
        jcnt <= jcnt + ADDR_W'(1);
      end
    end
  end

  assign bus.Jout  = mem[DEPTH-1];
  assign bus.Jcnt  = jcnt;
  assign bus.Jdone = jdone;

  // Registered read samples pre-edge contents, so a same-address write returns the
  // old word; it keeps tracking Addr while a scan is in progress.
  generate
    if (READ_REG) begin : gReadReg
      logic [WIDTH-1:0] doutReg;
      always_ff @(posedge clk) begin
        if (reset) begin
          doutReg <= '0;
        end else begin
          doutReg <= mem[bus.Addr];
        end
      end
      assign bus.Dout = doutReg;
    end else begin : gReadComb
      assign bus.Dout = mem[bus.Addr];
    end
  endgenerate

endmodule

// File: tb/tb_jtag_ram_param.sv
// tb_jtag_ram_param
//  Drives two 8x32 instances (combinational and registered read) with identical
//  stimulus and one 16x8 registered-read instance. Expected values come from a
//  word-queue model of the RAM contents plus a running shift total.
module tb_jtag_ram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [2:0]  a8;
  logic [31:0] d8, ji8;
  logic        w8, je8, jr8;
  logic [3:0]  a16;
  logic [7:0]  d16, ji16;
  logic        w16, je16, jr16;

  int checks = 0;
  int errors = 0;

  logic [31:0] q8[$];
  int          shifts8;
  logic        expDone8;
  logic [31:0] expReg8;
  logic [7:0]  q16[$];
  int          shifts16;
  logic        expDone16;
  logic [7:0]  expReg16;

  jtag_ram_param_if #(.WIDTH(32), .ADDR_W(3)) ifA ();
  jtag_ram_param_if #(.WIDTH(32), .ADDR_W(3)) ifB ();
  jtag_ram_param_if #(.WIDTH(8),  .ADDR_W(4)) ifC ();

  assign ifA.Addr = a8;  assign ifA.Din = d8;  assign ifA.Wen = w8;
  assign ifA.Jen  = je8; assign ifA.Jrot = jr8; assign ifA.Jin = ji8;
  assign ifB.Addr = a8;  assign ifB.Din = d8;  assign ifB.Wen = w8;
  assign ifB.Jen  = je8; assign ifB.Jrot = jr8; assign ifB.Jin = ji8;
  assign ifC.Addr = a16; assign ifC.Din = d16; assign ifC.Wen = w16;
  assign ifC.Jen  = je16; assign ifC.Jrot = jr16; assign ifC.Jin = ji16;

  jtag_ram_param #(.WIDTH(32), .DEPTH(8), .ADDR_W(3), .READ_REG(1'b0)) dutA (
    .clk(clk), .reset(rst), .bus(ifA.slave));
  jtag_ram_param #(.WIDTH(32), .DEPTH(8), .ADDR_W(3), .READ_REG(1'b1)) dutB (
    .clk(clk), .reset(rst), .bus(ifB.slave));
  jtag_ram_param #(.WIDTH(8), .DEPTH(16), .ADDR_W(4), .READ_REG(1'b1)) dutC (
    .clk(clk), .reset(rst), .bus(ifC.slave));

  task automatic set8(input logic [2:0] a, input logic [31:0] d, input logic w,
                      input logic je, input logic jr, input logic [31:0] ji);
    a8 = a; d8 = d; w8 = w; je8 = je; jr8 = jr; ji8 = ji;
  endtask

  task automatic set16(input logic [3:0] a, input logic [7:0] d, input logic w,
                       input logic je, input logic jr, input logic [7:0] ji);
    a16 = a; d16 = d; w16 = w; je16 = je; jr16 = jr; ji16 = ji;
  endtask

  // One clock edge for the 8-deep pair; the model treats the RAM as a queue of words
  // where a shift pushes a new word at entry 0 and drops the top entry.
  task automatic tick8();
    logic [31:0] nw;
    @(posedge clk);
    if (rst) begin
      q8.delete();
      for (int i = 0; i < 8; i++) q8.push_back('0);
      shifts8 = 0; expDone8 = 1'b0; expReg8 = '0;
    end else begin
      expReg8  = q8[a8];
      expDone8 = 1'b0;
      if (je8) begin
        nw = jr8 ? q8[7] : ji8;
        q8.push_front(nw);
        void'(q8.pop_back());
        shifts8++;
        expDone8 = (shifts8 % 8 == 0);
      end else if (w8) begin
        q8[a8] = d8;
      end
    end
    #1;
  endtask

  task automatic tick16();
    logic [7:0] nw;
    @(posedge clk);
    if (rst) begin
      q16.delete();
      for (int i = 0; i < 16; i++) q16.push_back('0);
      shifts16 = 0; expDone16 = 1'b0; expReg16 = '0;
    end else begin
      expReg16  = q16[a16];
      expDone16 = 1'b0;
      if (je16) begin
        nw = jr16 ? q16[15] : ji16;
        q16.push_front(nw);
        void'(q16.pop_back());
        shifts16++;
        expDone16 = (shifts16 % 16 == 0);
      end else if (w16) begin
        q16[a16] = d16;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set8(3'($urandom), $urandom, 1'b1, 1'b1, 1'b0, $urandom);
    tick8();
    tick8();
    checks++; if (ifA.Jout !== 32'h0) begin errors++; $display("[TB] FAIL reset Jout got=%h exp=0", ifA.Jout); end
    checks++; if (ifA.Jcnt !== 3'd0) begin errors++; $display("[TB] FAIL reset Jcnt got=%0d exp=0", ifA.Jcnt); end
    checks++; if (ifA.Jdone !== 1'b0) begin errors++; $display("[TB] FAIL reset Jdone got=%b exp=0", ifA.Jdone); end
    checks++; if (ifA.Dout !== 32'h0) begin errors++; $display("[TB] FAIL reset DoutA got=%h exp=0", ifA.Dout); end
    checks++; if (ifB.Dout !== 32'h0) begin errors++; $display("[TB] FAIL reset DoutB got=%h exp=0", ifB.Dout); end
    rst = 1'b0;
  endtask

  task automatic test_host_rw();
    for (int a = 0; a < 8; a++) begin
      set8(3'(a), 32'h100 + a, 1'b1, 1'b0, 1'b0, $urandom);
      tick8();
    end
    for (int a = 0; a < 8; a++) begin
      set8(3'(a), $urandom, 1'b0, 1'b0, 1'b0, $urandom);
      #1;
      checks++; if (ifA.Dout !== 32'h100 + a) begin errors++; $display("[TB] FAIL hostReadA addr=%0d got=%h exp=%h", a, ifA.Dout, 32'h100 + a); end
      tick8();
      checks++; if (ifB.Dout !== expReg8) begin errors++; $display("[TB] FAIL hostReadB addr=%0d got=%h exp=%h", a, ifB.Dout, expReg8); end
    end
  endtask

  task automatic test_scan_load();
    for (int k = 0; k < 8; k++) begin
      set8(3'($urandom), $urandom, 1'b0, 1'b1, 1'b0, 32'hA0 + k);
      tick8();
      checks++; if (ifA.Jcnt !== 3'(shifts8 % 8)) begin errors++; $display("[TB] FAIL loadJcnt k=%0d got=%0d exp=%0d", k, ifA.Jcnt, shifts8 % 8); end
      checks++; if (ifA.Jdone !== expDone8) begin errors++; $display("[TB] FAIL loadJdone k=%0d got=%b exp=%b", k, ifA.Jdone, expDone8); end
    end
    set8(3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    #1;
    checks++; if (ifA.Jout !== 32'hA0) begin errors++; $display("[TB] FAIL loadJout got=%h exp=a0", ifA.Jout); end
    checks++; if (ifA.Dout !== 32'hA7) begin errors++; $display("[TB] FAIL loadMem0 got=%h exp=a7", ifA.Dout); end
    tick8();
    checks++; if (ifA.Jdone !== 1'b0) begin errors++; $display("[TB] FAIL loadJdoneDrop got=%b exp=0", ifA.Jdone); end
  endtask

  task automatic test_rotate();
    int pulses = 0;
    for (int k = 0; k < 8; k++) begin
      set8(3'($urandom), $urandom, 1'b0, 1'b1, 1'b1, $urandom);
      #1;
      checks++; if (ifA.Jout !== 32'hA0 + k) begin errors++; $display("[TB] FAIL rotJout k=%0d got=%h exp=%h", k, ifA.Jout, 32'hA0 + k); end
      tick8();
      if (ifA.Jdone === 1'b1) pulses++;
      checks++; if (ifB.Dout !== expReg8) begin errors++; $display("[TB] FAIL rotDoutB k=%0d got=%h exp=%h", k, ifB.Dout, expReg8); end
    end
    set8(3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    tick8();
    checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL rotPulses got=%0d exp=1", pulses); end
    for (int a = 0; a < 8; a++) begin
      a8 = 3'(a);
      #1;
      checks++; if (ifA.Dout !== 32'hA7 - a) begin errors++; $display("[TB] FAIL rotKeep addr=%0d got=%h exp=%h", a, ifA.Dout, 32'hA7 - a); end
    end
  endtask

  task automatic test_jen_priority();
    set8(3'd3, 32'hDEAD, 1'b1, 1'b1, 1'b0, $urandom);
    tick8();
    for (int a = 0; a < 8; a++) begin
      set8(3'(a), 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      checks++; if (ifA.Dout !== q8[a]) begin errors++; $display("[TB] FAIL prioShift addr=%0d got=%h exp=%h", a, ifA.Dout, q8[a]); end
    end
    set8(3'd3, 32'hDEAD, 1'b1, 1'b0, 1'b0, $urandom);
    tick8();
    w8 = 1'b0;
    #1;
    checks++; if (ifA.Dout !== 32'hDEAD) begin errors++; $display("[TB] FAIL prioWrite got=%h exp=dead", ifA.Dout); end
  endtask

  task automatic test_gap();
    rst = 1'b1; set8(3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0); tick8(); rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      set8(3'($urandom), $urandom, 1'b0, 1'b1, 1'b0, $urandom);
      tick8();
    end
    for (int k = 0; k < 3; k++) begin
      set8(3'($urandom), $urandom, 1'b1, 1'b0, 1'b0, $urandom);
      tick8();
      checks++; if (ifA.Jcnt !== 3'd5) begin errors++; $display("[TB] FAIL gapJcnt k=%0d got=%0d exp=5", k, ifA.Jcnt); end
      checks++; if (ifA.Jdone !== 1'b0) begin errors++; $display("[TB] FAIL gapJdone k=%0d got=%b exp=0", k, ifA.Jdone); end
    end
    for (int k = 0; k < 3; k++) begin
      set8(3'($urandom), $urandom, 1'b0, 1'b1, 1'b0, $urandom);
      tick8();
      checks++; if (ifA.Jdone !== (k == 2)) begin errors++; $display("[TB] FAIL gapDone k=%0d got=%b exp=%b", k, ifA.Jdone, k == 2); end
    end
  endtask

  task automatic test_reset_midscan();
    for (int k = 0; k < 4; k++) begin
      set8(3'($urandom), $urandom, 1'b0, 1'b1, 1'b0, $urandom | 32'h1);
      tick8();
    end
    rst = 1'b1;
    set8(3'($urandom), $urandom, 1'b1, 1'b1, 1'b0, $urandom);
    tick8();
    rst = 1'b0;
    for (int a = 0; a < 8; a++) begin
      set8(3'(a), 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
      #1;
      checks++; if (ifA.Dout !== 32'h0) begin errors++; $display("[TB] FAIL midRstMem addr=%0d got=%h exp=0", a, ifA.Dout); end
    end
    checks++; if (ifA.Jcnt !== 3'd0) begin errors++; $display("[TB] FAIL midRstJcnt got=%0d exp=0", ifA.Jcnt); end
    for (int k = 0; k < 4; k++) begin
      set8(3'($urandom), $urandom, 1'b0, 1'b1, 1'b0, $urandom);
      tick8();
      checks++; if (ifA.Jdone !== 1'b0) begin errors++; $display("[TB] FAIL midRstJdone k=%0d got=%b exp=0", k, ifA.Jdone); end
    end
    checks++; if (ifA.Jcnt !== 3'd4) begin errors++; $display("[TB] FAIL midRstCount got=%0d exp=4", ifA.Jcnt); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      rst = ($urandom_range(0, 49) == 0);
      set8(3'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
      tick8();
      checks++; if (ifA.Jout !== q8[7]) begin errors++; $display("[TB] FAIL rndJout n=%0d got=%h exp=%h", n, ifA.Jout, q8[7]); end
      checks++; if (ifA.Jcnt !== 3'(shifts8 % 8)) begin errors++; $display("[TB] FAIL rndJcnt n=%0d got=%0d exp=%0d", n, ifA.Jcnt, shifts8 % 8); end
      checks++; if (ifA.Jdone !== expDone8) begin errors++; $display("[TB] FAIL rndJdone n=%0d got=%b exp=%b", n, ifA.Jdone, expDone8); end
      checks++; if (ifA.Dout !== q8[a8]) begin errors++; $display("[TB] FAIL rndDoutA n=%0d got=%h exp=%h", n, ifA.Dout, q8[a8]); end
      checks++; if (ifB.Dout !== expReg8) begin errors++; $display("[TB] FAIL rndDoutB n=%0d got=%h exp=%h", n, ifB.Dout, expReg8); end
    end
    rst = 1'b0;
  endtask

  task automatic test_depth16();
    int pulses = 0;
    rst = 1'b1; set16(4'd0, 8'h0, 1'b1, 1'b1, 1'b0, 8'h5A); tick16(); rst = 1'b0;
    checks++; if (ifC.Jout !== 8'h0 || ifC.Dout !== 8'h0 || ifC.Jcnt !== 4'd0 || ifC.Jdone !== 1'b0) begin
      errors++; $display("[TB] FAIL d16Reset Jout=%h Dout=%h Jcnt=%0d Jdone=%b exp all 0", ifC.Jout, ifC.Dout, ifC.Jcnt, ifC.Jdone);
    end
    for (int a = 0; a < 16; a++) begin
      set16(4'(a), 8'($urandom), 1'b1, 1'b0, 1'b0, 8'($urandom));
      tick16();
    end
    for (int a = 0; a < 16; a++) begin
      set16(4'(a), 8'h0, 1'b0, 1'b0, 1'b0, 8'h0);
      tick16();
      checks++; if (ifC.Dout !== expReg16) begin errors++; $display("[TB] FAIL d16Read addr=%0d got=%h exp=%h", a, ifC.Dout, expReg16); end
    end
    for (int k = 0; k < 16; k++) begin
      set16(4'($urandom), 8'($urandom), 1'b1, 1'b1, 1'b0, 8'(8'hA0 + k));
      tick16();
      checks++; if (ifC.Jcnt !== 4'(shifts16 % 16) || ifC.Jdone !== expDone16) begin
        errors++; $display("[TB] FAIL d16Load k=%0d Jcnt=%0d Jdone=%b exp %0d %b", k, ifC.Jcnt, ifC.Jdone, shifts16 % 16, expDone16);
      end
    end
    for (int k = 0; k < 16; k++) begin
      set16(4'($urandom), 8'($urandom), 1'b0, 1'b1, 1'b1, 8'($urandom));
      #1;
      checks++; if (ifC.Jout !== 8'(8'hA0 + k)) begin errors++; $display("[TB] FAIL d16Rot k=%0d got=%h exp=%h", k, ifC.Jout, 8'(8'hA0 + k)); end
      tick16();
      if (ifC.Jdone === 1'b1) pulses++;
    end
    checks++; if (pulses !== 1) begin errors++; $display("[TB] FAIL d16Pulses got=%0d exp=1", pulses); end
    for (int a = 0; a < 16; a++) begin
      set16(4'(a), 8'h0, 1'b0, 1'b0, 1'b0, 8'h0);
      tick16();
      checks++; if (ifC.Dout !== 8'(8'hAF - a)) begin errors++; $display("[TB] FAIL d16Keep addr=%0d got=%h exp=%h", a, ifC.Dout, 8'(8'hAF - a)); end
    end
  endtask

  initial begin
    rst = 1'b1;
    set8(3'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
    set16(4'd0, 8'h0, 1'b0, 1'b0, 1'b0, 8'h0);
    $display("[TB] start");
    test_reset();
    test_host_rw();
    test_scan_load();
    test_rotate();
    test_jen_priority();
    test_gap();
    test_reset_midscan();
    test_random();
    test_depth16();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
